// File: rtl/accel_spi_reader.sv
// accel_spi_reader
// SPI mode-3 master for an ADXL345-class accelerometer on the pixel clock.
// After a power-up delay it writes POWER_CTL (measure mode) once. It then
// burst-reads DATAX0..DATAY1 on a fixed poll period and presents the X/Y
// samples as saturated 8-bit signed values with a one-cycle update strobe.
module accel_spi_reader #(
  parameter int unsigned CLK_DIV        = 9,
  parameter int unsigned POLL_PERIOD    = 36000,
  parameter int unsigned STARTUP_CYCLES = 72000
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic [7:0] accel_data_x,
  output logic [7:0] accel_data_y,
  output logic       data_valid
);

  localparam int unsigned WAIT_MAX = (STARTUP_CYCLES > 2 * CLK_DIV) ? STARTUP_CYCLES : 2 * CLK_DIV;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
  localparam int unsigned POLL_W   = $clog2(POLL_PERIOD + 1);

  // POWER_CTL (0x2D) <= 0x08 : measure mode
  localparam logic [15:0] INIT_FRAME = 16'h2D08;
  // read | multi-byte | DATAX0 (0x32)
  localparam logic [7:0]  READ_CMD   = 8'hF2;

  // Final SCLK-divider boundary of a frame: 2 edges per bit, then one more
  // half-period with SCLK high before chip select is released.
  localparam logic [6:0]  INIT_LAST_EDGE = 7'd32;
  localparam logic [6:0]  READ_LAST_EDGE = 7'd80;

  typedef enum logic [2:0] {
    STARTUP,
    INIT_XFER,
    GAP,
    IDLE,
    READ_XFER
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [6:0]          edge_cnt;
  logic [6:0]          last_edge;
  logic [39:0]         tx_sr;
  logic [31:0]         rx_sr;
  logic [POLL_W-1:0]   poll_cnt;
  logic                poll_run;
  logic                poll_tick;
  logic                pending;
  logic [15:0]         x_raw;
  logic [15:0]         y_raw;

  // Clamp a signed 16-bit sample to +/-511 and keep bits [9:2].
  function automatic logic [7:0] sat8(input logic [15:0] s);
    logic [7:0] r;
    if (!s[15] && (s[14:9] != '0)) begin
      r = 8'h7F;
    end else if (s[15] && (s[14:9] != '1)) begin
      r = 8'h80;
    end else begin
      r = s[9:2];
    end
    return r;
  endfunction

  // Poll tick decode, frame length select and sample reassembly.
  always_comb begin
    poll_tick = poll_run && (poll_cnt == POLL_W'(POLL_PERIOD - 1));
    last_edge = (state == INIT_XFER) ? INIT_LAST_EDGE : READ_LAST_EDGE;
    // rx_sr holds X0, X1, Y0, Y1 from MSB down; samples are little-endian.
    x_raw     = {rx_sr[23:16], rx_sr[31:24]};
    y_raw     = {rx_sr[7:0],   rx_sr[15:8]};
  end

  // Free-running poll timer, started when the power-up delay expires.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
    end else if (poll_run) begin
      poll_cnt <= poll_tick ? '0 : poll_cnt + POLL_W'(1);
    end
  end

  // Sequencer: power-up delay, init write, gap, idle, periodic burst reads.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STARTUP;
      wait_cnt     <= '0;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      poll_run     <= 1'b0;
      pending      <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b1;
      spi_mosi     <= 1'b0;
      accel_data_x <= '0;
      accel_data_y <= '0;
      data_valid   <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // A tick that cannot start a read right now is remembered (depth 1).
      if (poll_tick && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        STARTUP: begin
          if (wait_cnt == WAIT_W'(STARTUP_CYCLES - 1)) begin
            state    <= INIT_XFER;
            poll_run <= 1'b1;
            spi_cs_n <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= {INIT_FRAME, 24'h0};
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        INIT_XFER, READ_XFER: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (edge_cnt == last_edge) begin
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              state    <= GAP;
              wait_cnt <= '0;
              if (state == READ_XFER) begin
                accel_data_x <= sat8(x_raw);
                accel_data_y <= sat8(y_raw);
                data_valid   <= 1'b1;
              end
            end else begin
              edge_cnt <= edge_cnt + 7'd1;
              spi_sclk <= ~spi_sclk;
              if (!edge_cnt[0]) begin
                // falling edge: present next command bit
                spi_mosi <= tx_sr[39];
                tx_sr    <= {tx_sr[38:0], 1'b0};
              end else begin
                // rising edge: capture sensor data
                rx_sr <= {rx_sr[30:0], spi_miso};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // GAP spans 2*CLK_DIV-1 cycles; the following IDLE cycle completes
        // the minimum 2*CLK_DIV chip-select-high time before a pending read.
        GAP: begin
          if (wait_cnt == WAIT_W'(2 * CLK_DIV - 2)) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        IDLE: begin
          if (poll_tick || pending) begin
            state    <= READ_XFER;
            pending  <= 1'b0;
            spi_cs_n <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= {READ_CMD, 32'h0};
          end
        end

        default: state <= STARTUP;
      endcase
    end
  end

endmodule
